sha256_nonce_scheduler: RTL and testbench

//  Sequences one shared single-block SHA-256 core through the Bitcoin double hash over a nonce range.
//  Per job: block 1 (header words 0-15) once, producing the midstate.
//  Per nonce: block 2 (header words 16-18, nonce, padding) from the midstate.

---
 rtl/sha256_pkg.sv | 49 ++++
 rtl/sha256_nonce_scheduler.sv | 147 ++++++++++++++
 tb/tb_sha256_nonce_scheduler.sv | 529 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sha256_pkg.sv
// Shared constants, block builders and scheduler state type for the SHA-256 nonce scheduler.
package sha256_pkg;

    localparam logic [7:0][31:0] H_INIT = {
        32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
        32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
    };

    localparam logic [31:0] PAD_ONE  = 32'h80000000;
    localparam logic [31:0] LEN_BLK2 = 32'd640;
    localparam logic [31:0] LEN_BLK3 = 32'd256;

    typedef enum logic [3:0] {
        StIdle,
        StB1Go,
        StB1Wait,
        StB2Go,
        StB2Wait,
        StB3Go,
        StB3Wait,
        StEmit,
        StFin
    } sched_state_t;

    // Second header block: last three header words, nonce, padding, 640-bit length.
    function automatic logic [15:0][31:0] blk2_msg(input logic [2:0][31:0] tail,
                                                   input logic [31:0]      nonce);
        logic [15:0][31:0] m;
        m     = '0;
        m[0]  = tail[0];
        m[1]  = tail[1];
        m[2]  = tail[2];
        m[3]  = nonce;
        m[4]  = PAD_ONE;
        m[15] = LEN_BLK2;
        return m;
    endfunction

    // Outer hash block: the 256-bit inner digest, padding, 256-bit length.
    function automatic logic [15:0][31:0] blk3_msg(input logic [7:0][31:0] dig);
        logic [15:0][31:0] m;
        m      = '0;
        m[7:0] = dig;
        m[8]   = PAD_ONE;
        m[15]  = LEN_BLK3;
        return m;
    endfunction

endpackage

// File: rtl/sha256_nonce_scheduler.sv
// Drives one shared SHA-256 core through the Bitcoin double hash for a range of nonces,
// reusing the block-1 midstate and streaming {nonce, H0} results with a valid/ready handshake.
module sha256_nonce_scheduler
    import sha256_pkg::*;
#(
    parameter int unsigned NUM_NONCES = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [18:0][31:0] header,
    input  logic [31:0]       nonce_base,
    output logic              core_start,
    output logic [15:0][31:0] core_message,
    output logic [7:0][31:0]  core_hash,
    input  logic              core_done,
    input  logic [7:0][31:0]  core_sha,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [31:0]       res_nonce,
    output logic [31:0]       res_h0,
    output logic              busy,
    output logic              done
);

    localparam int unsigned CNT_W = $clog2(NUM_NONCES + 1);

    sched_state_t     state;
    logic [31:0]      nonce;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_inc;
    logic [7:0][31:0] midstate;
    logic [7:0][31:0] digest;
    logic             abort_seen;

    assign count_inc = count + CNT_W'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= StIdle;
            core_start <= 1'b0;
            res_valid  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            res_nonce  <= '0;
            res_h0     <= '0;
            nonce      <= '0;
            count      <= '0;
            midstate   <= '0;
            digest     <= '0;
            abort_seen <= 1'b0;
        end else begin
            core_start <= 1'b0;
            done       <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        nonce      <= nonce_base;
                        count      <= '0;
                        abort_seen <= 1'b0;
                        busy       <= 1'b1;
                        state      <= StB1Go;
                    end
                end
                StB1Go, StB2Go, StB3Go: begin
                    if (abort) begin
                        done  <= 1'b1;
                        state <= StFin;
                    end else begin
                        core_start <= 1'b1;
                        state      <= (state == StB1Go) ? StB1Wait :
                                      (state == StB2Go) ? StB2Wait : StB3Wait;
                    end
                end
                StB1Wait, StB2Wait, StB3Wait: begin
                    // An abort seen while the core runs is remembered until the core finishes.
                    if (abort) begin
                        abort_seen <= 1'b1;
                    end
                    if (core_done) begin
                        if (abort || abort_seen) begin
                            done  <= 1'b1;
                            state <= StFin;
                        end else if (state == StB1Wait) begin
                            midstate <= core_sha;
                            state    <= StB2Go;
                        end else if (state == StB2Wait) begin
                            digest <= core_sha;
                            state  <= StB3Go;
                        end else begin
                            res_h0    <= core_sha[0];
                            res_nonce <= nonce;
                            res_valid <= 1'b1;
                            state     <= StEmit;
                        end
                    end
                end
                StEmit: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        nonce     <= nonce + 32'd1;
                        count     <= count_inc;
                        if ((count_inc < CNT_W'(NUM_NONCES)) && !abort) begin
                            state <= StB2Go;
                        end else begin
                            done  <= 1'b1;
                            state <= StFin;
                        end
                    end
                end
                StFin: begin
                    busy  <= 1'b0;
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

    // Block selection follows the state, so message and hash stay fixed for the whole wait.
    always_comb begin
        core_message = '0;
        core_hash    = '0;
        unique case (state)
            StB1Go, StB1Wait: begin
                core_message = header[15:0];
                core_hash    = H_INIT;
            end
            StB2Go, StB2Wait: begin
                core_message = blk2_msg(header[18:16], nonce);
                core_hash    = midstate;
            end
            StB3Go, StB3Wait: begin
                core_message = blk3_msg(digest);
                core_hash    = H_INIT;
            end
            default: begin
                core_message = '0;
                core_hash    = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_sha256_nonce_scheduler.sv
// Bench: two scheduler instances (1 and 16 nonces), each with a behavioural SHA-256 core,
// checked against a full double-SHA-256 reference built from standard message padding.
module tb_sha256_nonce_scheduler;

    localparam logic [7:0][31:0] HI = {
        32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
        32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
    };

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
        32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
        32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
        32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
        32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
        32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic              clk = 1'b0;
    logic              reset_n;
    logic [1:0]        start;
    logic              abort;
    logic [18:0][31:0] header;
    logic [31:0]       nonce_base;
    logic              res_ready;
    logic [1:0]        inj_done;

    logic              core_start   [2];
    logic [15:0][31:0] core_message [2];
    logic [7:0][31:0]  core_hash    [2];
    logic [1:0]        cd_q;
    logic [1:0]        core_done;
    logic [7:0][31:0]  sha_r        [2];
    logic              res_valid    [2];
    logic [31:0]       res_nonce    [2];
    logic [31:0]       res_h0       [2];
    logic              busy         [2];
    logic              done         [2];

    // Core-model and monitor bookkeeping; counters only ever increase.
    int                remaining [2];
    logic [15:0][31:0] msg_seen  [2];
    logic [7:0][31:0]  hash_seen [2];
    logic [15:0][31:0] msg_log   [2][256];
    int                cs_cnt    [2] = '{0, 0};
    int                ops_cnt   [2] = '{0, 0};
    int                b1_cnt    [2] = '{0, 0};
    int                stab_err  [2] = '{0, 0};
    logic [31:0]       rn_log    [2][256];
    logic [31:0]       rh_log    [2][256];
    int                res_cnt   [2] = '{0, 0};
    int                done_cnt  [2] = '{0, 0};

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign core_done = cd_q | inj_done;

    sha256_nonce_scheduler #(.NUM_NONCES(1)) u_dut_one (
        .clk(clk), .reset_n(reset_n), .start(start[0]), .abort(abort), .header(header),
        .nonce_base(nonce_base), .core_start(core_start[0]), .core_message(core_message[0]),
        .core_hash(core_hash[0]), .core_done(core_done[0]), .core_sha(sha_r[0]),
        .res_valid(res_valid[0]), .res_ready(res_ready), .res_nonce(res_nonce[0]),
        .res_h0(res_h0[0]), .busy(busy[0]), .done(done[0])
    );

    sha256_nonce_scheduler #(.NUM_NONCES(16)) u_dut_multi (
        .clk(clk), .reset_n(reset_n), .start(start[1]), .abort(abort), .header(header),
        .nonce_base(nonce_base), .core_start(core_start[1]), .core_message(core_message[1]),
        .core_hash(core_hash[1]), .core_done(core_done[1]), .core_sha(sha_r[1]),
        .res_valid(res_valid[1]), .res_ready(res_ready), .res_nonce(res_nonce[1]),
        .res_h0(res_h0[1]), .busy(busy[1]), .done(done[1])
    );

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [7:0][31:0] sha_compress(input logic [7:0][31:0]  h,
                                                      input logic [15:0][31:0] m);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, gg, hh, s0, s1, t1, t2;
        logic [7:0][31:0] r;
        for (int i = 0; i < 16; i++) w[i] = m[i];
        for (int i = 16; i < 64; i++) begin
            s0   = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
            s1   = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = w[i-16] + s0 + w[i-7] + s1;
        end
        a = h[0]; b = h[1]; c = h[2]; d = h[3]; e = h[4]; f = h[5]; gg = h[6]; hh = h[7];
        for (int i = 0; i < 64; i++) begin
            t1 = hh + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & gg)) + K[i] + w[i];
            t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            hh = gg; gg = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        r[0] = h[0] + a; r[1] = h[1] + b; r[2] = h[2] + c; r[3] = h[3] + d;
        r[4] = h[4] + e; r[5] = h[5] + f; r[6] = h[6] + gg; r[7] = h[7] + hh;
        return r;
    endfunction

    // Full SHA-256 of n big-endian words with standard padding.
    function automatic logic [7:0][31:0] sha256_words(input logic [31:0] words [32], input int n);
        logic [31:0]       pad_w [48];
        logic [15:0][31:0] blk;
        logic [7:0][31:0]  st;
        int                nblk;
        nblk = (n + 3 + 15) / 16;
        for (int i = 0; i < 48; i++) pad_w[i] = (i < n) ? words[i] : 32'h0;
        pad_w[n]             = 32'h80000000;
        pad_w[nblk * 16 - 1] = 32'(n * 32);
        st = HI;
        for (int bi = 0; bi < nblk; bi++) begin
            for (int j = 0; j < 16; j++) blk[j] = pad_w[bi * 16 + j];
            st = sha_compress(st, blk);
        end
        return st;
    endfunction

    function automatic logic [31:0] ref_h0(input logic [18:0][31:0] hdr, input logic [31:0] nc);
        logic [31:0]      words [32];
        logic [7:0][31:0] d1;
        logic [7:0][31:0] d2;
        for (int i = 0; i < 32; i++) words[i] = 32'h0;
        for (int i = 0; i < 19; i++) words[i] = hdr[i];
        words[19] = nc;
        d1 = sha256_words(words, 20);
        for (int i = 0; i < 32; i++) words[i] = (i < 8) ? d1[i] : 32'h0;
        d2 = sha256_words(words, 8);
        return d2[0];
    endfunction

    // Behavioural core: random latency, re-reads its inputs every busy cycle.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int g = 0; g < 2; g++) begin
                remaining[g] <= 0;
                sha_r[g]     <= '0;
            end
            cd_q <= '0;
        end else begin
            for (int g = 0; g < 2; g++) begin
                cd_q[g] <= 1'b0;
                if (core_start[g]) begin
                    remaining[g]             <= int'($urandom_range(6, 2));
                    msg_seen[g]              <= core_message[g];
                    hash_seen[g]             <= core_hash[g];
                    msg_log[g][cs_cnt[g] % 256] <= core_message[g];
                    if (core_message[g] == header[15:0] && core_hash[g] == HI)
                        b1_cnt[g] <= b1_cnt[g] + 1;
                    cs_cnt[g] <= cs_cnt[g] + 1;
                end else if (remaining[g] > 0) begin
                    if (core_message[g] !== msg_seen[g] || core_hash[g] !== hash_seen[g])
                        stab_err[g] <= stab_err[g] + 1;
                    if (remaining[g] == 1) begin
                        cd_q[g]    <= 1'b1;
                        sha_r[g]   <= sha_compress(core_hash[g], core_message[g]);
                        ops_cnt[g] <= ops_cnt[g] + 1;
                    end
                    remaining[g] <= remaining[g] - 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (res_valid[g] && res_ready) begin
                rn_log[g][res_cnt[g] % 256] <= res_nonce[g];
                rh_log[g][res_cnt[g] % 256] <= res_h0[g];
                res_cnt[g] <= res_cnt[g] + 1;
            end
            if (done[g]) done_cnt[g] <= done_cnt[g] + 1;
        end
    end

    task automatic pulse_start(input int sel);
        @(posedge clk); #1; start[sel] = 1'b1;
        @(posedge clk); #1; start[sel] = 1'b0;
    endtask

    task automatic accept();
        @(posedge clk); #1; res_ready = 1'b1;
        @(posedge clk); #1; res_ready = 1'b0;
    endtask

    task automatic wait_done(input int sel, input int base, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk); #1;
            if (done_cnt[sel] != base) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_valid(input int sel, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (res_valid[sel]) begin ok = 1'b1; break; end
        end
    endtask

    task automatic rand_header();
        for (int i = 0; i < 19; i++) header[i] = $urandom;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 2'b11; abort = 1'b0; res_ready = 1'b0; inj_done = '0;
        header = '0; nonce_base = 32'h12345678;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            n_checks++;
            if ({core_start[s], res_valid[s], busy[s], done[s]} !== 4'b0) begin
                n_fail++;
                $display("FAIL reset_ctrl[%0d]: got %b, want 0000", s,
                         {core_start[s], res_valid[s], busy[s], done[s]});
            end
            n_checks++;
            if ({res_nonce[s], res_h0[s]} !== 64'h0 || core_message[s] !== '0 ||
                core_hash[s] !== '0) begin
                n_fail++;
                $display("FAIL reset_data[%0d]: nonce %h h0 %h, want 0", s, res_nonce[s],
                         res_h0[s]);
            end
        end
        #1 start = 2'b00;
        @(posedge clk); #1 reset_n = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy[0] !== 1'b0 || busy[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: busy %b%b, want 00", busy[1], busy[0]);
        end
    endtask

    task automatic test_single_nonce();
        int cs0, r0, d0;
        bit ok;
        logic [31:0] exp_h0;
        header = '0; nonce_base = 32'h0; res_ready = 1'b1;
        cs0 = cs_cnt[0]; r0 = res_cnt[0]; d0 = done_cnt[0];
        exp_h0 = ref_h0(header, 32'h0);
        pulse_start(0);
        wait_done(0, d0, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL single_done: no done pulse, want 1"); end
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if (cs_cnt[0] - cs0 != 3) begin
            n_fail++; $display("FAIL single_starts: got %0d, want 3", cs_cnt[0] - cs0);
        end
        n_checks++;
        if ({msg_log[0][(cs0+1)%256][3], msg_log[0][(cs0+1)%256][4],
             msg_log[0][(cs0+1)%256][15]} !== {32'h0, 32'h80000000, 32'h00000280}) begin
            n_fail++;
            $display("FAIL blk2_words: got %h %h %h, want 0 80000000 280",
                     msg_log[0][(cs0+1)%256][3], msg_log[0][(cs0+1)%256][4],
                     msg_log[0][(cs0+1)%256][15]);
        end
        n_checks++;
        if ({msg_log[0][(cs0+2)%256][8], msg_log[0][(cs0+2)%256][15]} !==
            {32'h80000000, 32'h00000100}) begin
            n_fail++;
            $display("FAIL blk3_words: got %h %h, want 80000000 100",
                     msg_log[0][(cs0+2)%256][8], msg_log[0][(cs0+2)%256][15]);
        end
        n_checks++;
        if (res_cnt[0] - r0 != 1 || rh_log[0][r0%256] !== exp_h0 ||
            rn_log[0][r0%256] !== 32'h0) begin
            n_fail++;
            $display("FAIL single_result: n=%0d h0 %h nonce %h, want 1 %h 0", res_cnt[0] - r0,
                     rh_log[0][r0%256], rn_log[0][r0%256], exp_h0);
        end
        n_checks++;
        if (done_cnt[0] - d0 != 1 || busy[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL single_done_once: got %0d busy %b, want 1 0", done_cnt[0] - d0,
                     busy[0]);
        end
    endtask

    task automatic test_wrap_stream();
        int cs0, r0, d0, b0, st0;
        bit ok;
        logic [31:0] exp_n;
        rand_header(); nonce_base = 32'hFFFFFFFE; res_ready = 1'b1;
        cs0 = cs_cnt[1]; r0 = res_cnt[1]; d0 = done_cnt[1]; b0 = b1_cnt[1]; st0 = stab_err[1];
        pulse_start(1);
        wait_done(1, d0, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL wrap_done: timeout, want done"); end
        n_checks++;
        if (res_cnt[1] - r0 != 16) begin
            n_fail++; $display("FAIL wrap_count: got %0d, want 16", res_cnt[1] - r0);
        end
        for (int k = 0; k < 16; k++) begin
            exp_n = 32'hFFFFFFFE + 32'(k);
            n_checks++;
            if (rn_log[1][(r0+k)%256] !== exp_n || rh_log[1][(r0+k)%256] !== ref_h0(header, exp_n))
            begin
                n_fail++;
                $display("FAIL wrap_result[%0d]: got %h/%h, want %h/%h", k, rn_log[1][(r0+k)%256],
                         rh_log[1][(r0+k)%256], exp_n, ref_h0(header, exp_n));
            end
        end
        n_checks++;
        if (b1_cnt[1] - b0 != 1 || cs_cnt[1] - cs0 != 33) begin
            n_fail++;
            $display("FAIL wrap_starts: blk1 %0d total %0d, want 1 33", b1_cnt[1] - b0,
                     cs_cnt[1] - cs0);
        end
        n_checks++;
        if (stab_err[1] != st0) begin
            n_fail++; $display("FAIL core_input_stable: got %0d changes, want 0", stab_err[1] - st0);
        end
    endtask

    task automatic test_backpressure();
        int r0, d0, cs_snap, bad;
        bit ok;
        logic [31:0] snap_n, snap_h;
        rand_header(); nonce_base = $urandom; res_ready = 1'b0;
        r0 = res_cnt[1]; d0 = done_cnt[1];
        pulse_start(1);
        for (int k = 0; k < 16; k++) begin
            wait_valid(1, ok);
            if (!ok) begin
                n_checks++; n_fail++;
                $display("FAIL bp_valid[%0d]: timeout, want res_valid", k);
                break;
            end
            if (k == 2) begin
                snap_n = res_nonce[1]; snap_h = res_h0[1]; cs_snap = cs_cnt[1]; bad = 0;
                repeat (20) begin
                    @(negedge clk);
                    if (res_valid[1] !== 1'b1 || res_nonce[1] !== snap_n || res_h0[1] !== snap_h)
                        bad++;
                end
                n_checks++;
                if (bad != 0) begin
                    n_fail++; $display("FAIL bp_hold: got %0d unstable cycles, want 0", bad);
                end
                n_checks++;
                if (cs_cnt[1] != cs_snap) begin
                    n_fail++;
                    $display("FAIL bp_no_start: got %0d starts, want 0", cs_cnt[1] - cs_snap);
                end
                n_checks++;
                if (snap_n !== nonce_base + 32'd2 || snap_h !== ref_h0(header, nonce_base + 32'd2))
                begin
                    n_fail++;
                    $display("FAIL bp_value: got %h/%h, want %h/%h", snap_n, snap_h,
                             nonce_base + 32'd2, ref_h0(header, nonce_base + 32'd2));
                end
            end
            accept();
        end
        wait_done(1, d0, ok);
        n_checks++;
        if (!ok || res_cnt[1] - r0 != 16) begin
            n_fail++; $display("FAIL bp_total: got %0d results, want 16", res_cnt[1] - r0);
        end
        bad = 0;
        for (int k = 0; k < 16; k++)
            if (rh_log[1][(r0+k)%256] !== ref_h0(header, nonce_base + 32'(k))) bad++;
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL bp_stream: got %0d wrong h0, want 0", bad); end
    endtask

    task automatic test_abort();
        int cs0, r0, d0, op0, bad;
        bit ok;
        rand_header(); nonce_base = $urandom; res_ready = 1'b1;
        cs0 = cs_cnt[1]; r0 = res_cnt[1]; d0 = done_cnt[1]; op0 = ops_cnt[1];
        pulse_start(1);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk); #1;
            if (cs_cnt[1] - cs0 == 12) begin ok = 1'b1; break; end
        end
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL abort_reach: timeout, want 12 starts"); end
        abort = 1'b1;
        wait_done(1, d0, ok);
        n_checks++;
        if (!ok || ops_cnt[1] - op0 != 12) begin
            n_fail++;
            $display("FAIL abort_core_finish: got %0d ops at done, want 12", ops_cnt[1] - op0);
        end
        abort = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        n_checks++;
        if (res_cnt[1] - r0 != 5 || cs_cnt[1] - cs0 != 12 || busy[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_end: results %0d starts %0d busy %b, want 5 12 0",
                     res_cnt[1] - r0, cs_cnt[1] - cs0, busy[1]);
        end
        n_checks++;
        if (done_cnt[1] - d0 != 1) begin
            n_fail++; $display("FAIL abort_done: got %0d pulses, want 1", done_cnt[1] - d0);
        end
        bad = 0;
        for (int k = 0; k < 5; k++)
            if (rn_log[1][(r0+k)%256] !== nonce_base + 32'(k) ||
                rh_log[1][(r0+k)%256] !== ref_h0(header, nonce_base + 32'(k))) bad++;
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL abort_stream: got %0d wrong, want 0", bad); end
    endtask

    task automatic test_ignored_inputs();
        int cs0, r0, d0, bad;
        bit ok;
        rand_header(); nonce_base = $urandom; res_ready = 1'b0;
        cs0 = cs_cnt[1]; r0 = res_cnt[1]; d0 = done_cnt[1];
        pulse_start(1);
        repeat (2) @(posedge clk);
        pulse_start(1);
        for (int k = 0; k < 16; k++) begin
            wait_valid(1, ok);
            if (!ok) begin
                n_checks++; n_fail++;
                $display("FAIL ign_valid[%0d]: timeout, want res_valid", k);
                break;
            end
            if (k < 4) begin
                @(posedge clk); #1; inj_done[1] = 1'b1; start[1] = 1'b1;
                @(posedge clk); #1; inj_done[1] = 1'b0; start[1] = 1'b0;
                @(negedge clk);
                n_checks++;
                if (res_valid[1] !== 1'b1 || res_nonce[1] !== nonce_base + 32'(k)) begin
                    n_fail++;
                    $display("FAIL ign_emit[%0d]: valid %b nonce %h, want 1 %h", k, res_valid[1],
                             res_nonce[1], nonce_base + 32'(k));
                end
            end
            accept();
        end
        wait_done(1, d0, ok);
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if (!ok || done_cnt[1] - d0 != 1 || cs_cnt[1] - cs0 != 33) begin
            n_fail++;
            $display("FAIL ign_job: done %0d starts %0d, want 1 33", done_cnt[1] - d0,
                     cs_cnt[1] - cs0);
        end
        bad = 0;
        for (int k = 0; k < 16; k++)
            if (rn_log[1][(r0+k)%256] !== nonce_base + 32'(k) ||
                rh_log[1][(r0+k)%256] !== ref_h0(header, nonce_base + 32'(k))) bad++;
        n_checks++;
        if (res_cnt[1] - r0 != 16 || bad != 0) begin
            n_fail++;
            $display("FAIL ign_stream: got %0d results %0d wrong, want 16 0", res_cnt[1] - r0, bad);
        end
    endtask

    task automatic test_reset_mid_job();
        int cs0, r0, d0, bad;
        bit ok;
        rand_header(); nonce_base = $urandom; res_ready = 1'b1;
        cs0 = cs_cnt[1];
        pulse_start(1);
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk); #1;
            if (cs_cnt[1] - cs0 == 3) begin ok = 1'b1; break; end
        end
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL rst_reach_b3: timeout, want 3 starts"); end
        #1 reset_n = 1'b0;
        #1;
        n_checks++;
        if ({core_start[1], res_valid[1], busy[1], done[1]} !== 4'b0) begin
            n_fail++;
            $display("FAIL rst_async_ctrl: got %b, want 0000",
                     {core_start[1], res_valid[1], busy[1], done[1]});
        end
        n_checks++;
        if ({res_nonce[1], res_h0[1]} !== 64'h0 || core_message[1] !== '0 ||
            core_hash[1] !== '0) begin
            n_fail++;
            $display("FAIL rst_async_data: nonce %h h0 %h, want 0", res_nonce[1], res_h0[1]);
        end
        @(posedge clk); #1 reset_n = 1'b1;
        rand_header(); nonce_base = $urandom;
        r0 = res_cnt[1]; d0 = done_cnt[1];
        pulse_start(1);
        wait_done(1, d0, ok);
        bad = 0;
        for (int k = 0; k < 16; k++)
            if (rn_log[1][(r0+k)%256] !== nonce_base + 32'(k) ||
                rh_log[1][(r0+k)%256] !== ref_h0(header, nonce_base + 32'(k))) bad++;
        n_checks++;
        if (!ok || res_cnt[1] - r0 != 16 || bad != 0) begin
            n_fail++;
            $display("FAIL rst_fresh_job: got %0d results %0d wrong, want 16 0",
                     res_cnt[1] - r0, bad);
        end
    endtask

    initial begin
        test_reset();
        test_single_nonce();
        test_wrap_stream();
        test_backpressure();
        test_abort();
        test_ignored_inputs();
        test_reset_mid_job();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
